rv32i_fetch: RTL and testbench

RV32I_FETCH -- requirements
Module: rv32i_fetch

---
 rtl/rv32i_fetch.sv | 144 ++++++++++++++
 tb/tb_rv32i_fetch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: one outstanding request to instruction memory,
// a one-word hold buffer for decode stalls, and redirect handling with clear_o.
module rv32i_fetch #(
  parameter int                XLEN         = 32,
  parameter int                ILEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [XLEN-1:0]   jump_target_i,
  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [ILEN-1:0]   mem_data_i,
  output logic [ILEN-1:0]   instruction_o,
  output logic [XLEN-1:0]   pc_data_o,
  output logic              data_ready_o,
  output logic              clear_o
);

  localparam logic [ILEN-1:0] NOP_WORD = ILEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t            state_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   req_addr_reg;
  logic              mem_req_reg;
  logic [ILEN-1:0]   instr_reg;
  logic [XLEN-1:0]   pc_data_reg;
  logic              data_ready_reg;
  logic              clear_reg;
  logic [ILEN-1:0]   hold_buf_reg;

  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   target_aligned;

  // Wraps naturally modulo 2^XLEN; redirect targets are forced word-aligned.
  assign pc_next        = pc_reg + XLEN'(4);
  assign target_aligned = jump_target_i & ~XLEN'(3);

  // Invariant: in FETCH a request is always outstanding at req_addr_reg == pc_reg.
  // In DISCARD the request is still at the old address while pc_reg holds the target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_VECTOR;
      req_addr_reg   <= RESET_VECTOR;
      mem_req_reg    <= 1'b0;
      instr_reg      <= NOP_WORD;
      pc_data_reg    <= '0;
      data_ready_reg <= 1'b0;
      clear_reg      <= 1'b0;
      hold_buf_reg   <= '0;
    end else begin
      data_ready_reg <= 1'b0;
      clear_reg      <= 1'b0;

      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          mem_req_reg  <= 1'b1;
          req_addr_reg <= pc_reg;
        end

        FETCH: begin
          if (jump_i) begin
            pc_reg    <= target_aligned;
            clear_reg <= 1'b1;
            if (mem_ack_i) begin
              req_addr_reg <= target_aligned;
            end else begin
              state_reg <= DISCARD;
            end
          end else if (mem_ack_i) begin
            if (stall_i) begin
              hold_buf_reg <= mem_data_i;
              mem_req_reg  <= 1'b0;
              state_reg    <= HOLD;
            end else begin
              instr_reg      <= mem_data_i;
              pc_data_reg    <= pc_reg;
              data_ready_reg <= 1'b1;
              pc_reg         <= pc_next;
              req_addr_reg   <= pc_next;
            end
          end
        end

        HOLD: begin
          if (jump_i) begin
            pc_reg       <= target_aligned;
            clear_reg    <= 1'b1;
            mem_req_reg  <= 1'b1;
            req_addr_reg <= target_aligned;
            state_reg    <= FETCH;
          end else if (!stall_i) begin
            instr_reg      <= hold_buf_reg;
            pc_data_reg    <= pc_reg;
            data_ready_reg <= 1'b1;
            pc_reg         <= pc_next;
            mem_req_reg    <= 1'b1;
            req_addr_reg   <= pc_next;
            state_reg      <= FETCH;
          end
        end

        DISCARD: begin
          // The stale word is dropped; only the completion of the old request matters.
          if (jump_i) begin
            pc_reg    <= target_aligned;
            clear_reg <= 1'b1;
            if (mem_ack_i) begin
              req_addr_reg <= target_aligned;
              state_reg    <= FETCH;
            end
          end else if (mem_ack_i) begin
            req_addr_reg <= pc_reg;
            state_reg    <= FETCH;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o     = mem_req_reg;
  assign mem_addr_o    = req_addr_reg;
  assign instruction_o = instr_reg;
  assign pc_data_o     = pc_data_reg;
  assign data_ready_o  = data_ready_reg;
  assign clear_o       = clear_reg;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: a latency-programmable memory responder and a
// scoreboard of expected (pc, instruction) words presented to decode.
module tb_rv32i_fetch;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i         = 1'b1;
  logic        stall_i       = 1'b0;
  logic        jump_i        = 1'b0;
  logic [31:0] jump_target_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i     = 1'b0;
  logic [31:0] mem_data_i    = 32'h0;
  logic [31:0] instruction_o;
  logic [31:0] pc_data_o;
  logic        data_ready_o;
  logic        clear_o;

  // Second instance with a high reset vector and an always-ready memory.
  logic        rv_req;
  logic [31:0] rv_addr;
  logic        rv_ack;
  logic [31:0] rv_data;
  logic [31:0] rv_instr;
  logic [31:0] rv_pc;
  logic        rv_ready;
  logic        rv_clear;

  rv32i_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .jump_i(jump_i),
    .jump_target_i(jump_target_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .instruction_o(instruction_o),
    .pc_data_o(pc_data_o), .data_ready_o(data_ready_o), .clear_o(clear_o)
  );

  rv32i_fetch #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_rv (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(1'b0), .jump_i(1'b0),
    .jump_target_i(32'h0), .mem_req_o(rv_req), .mem_addr_o(rv_addr),
    .mem_ack_i(rv_ack), .mem_data_i(rv_data), .instruction_o(rv_instr),
    .pc_data_o(rv_pc), .data_ready_o(rv_ready), .clear_o(rv_clear)
  );

  assign rv_ack  = rv_req;
  assign rv_data = rv_addr;

  logic [31:0] rv_seen[$];
  always @(negedge clk_i) begin
    if (rv_ready && rv_seen.size() < 3) rv_seen.push_back(rv_pc);
  end

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          lat          = 1;
  logic [31:0] data_xor     = 32'h0;
  logic        force_ack    = 1'b0;
  int          wait_cnt     = 0;

  logic        pre_req  = 1'b0;
  logic        pre_ack  = 1'b0;
  logic        pre_rst  = 1'b1;
  logic [31:0] pre_addr = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // Memory responder: acks in the lat-th cycle a request is visible, word = addr ^ data_xor.
  always @(negedge clk_i) begin
    if (force_ack) begin
      mem_ack_i  <= 1'b1;
      mem_data_i <= 32'hDEAD_BEEF;
      wait_cnt   <= 0;
    end else if (rst_i || !mem_req_o) begin
      mem_ack_i <= 1'b0;
      wait_cnt  <= 0;
    end else if (wait_cnt + 1 >= lat) begin
      mem_ack_i  <= 1'b1;
      mem_data_i <= mem_addr_o ^ data_xor;
      wait_cnt   <= 0;
    end else begin
      mem_ack_i <= 1'b0;
      wait_cnt  <= wait_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ data_xor;
    exp_q.push_back(e);
  endtask

  // One clock: snapshot the pre-edge request/ack at negedge+1, then check at posedge+1.
  task automatic tick();
    exp_t e;
    @(negedge clk_i); #1;
    pre_req  = mem_req_o;
    pre_addr = mem_addr_o;
    pre_ack  = mem_ack_i;
    pre_rst  = rst_i;
    @(posedge clk_i); #1;
    if (!rst_i && !pre_rst) begin
      chk("clear_vs_ready", 32'(clear_o & data_ready_o), 32'd0);
      if (pre_req && !pre_ack) begin
        chk("req_held", 32'(mem_req_o), 32'd1);
        chk("addr_held", mem_addr_o, pre_addr);
      end
    end
    if (data_ready_o) begin
      $display("[TB] presented pc=%h instr=%h", pc_data_o, instruction_o);
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("word_pc", pc_data_o, e.pc);
        chk("word_instr", instruction_o, e.instr);
      end
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!data_ready_o && n < budget);
    chk(tag, 32'(data_ready_o), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(mem_req_o),    32'd0);
    chk({tag, "_addr"},  mem_addr_o,         32'h0);
    chk({tag, "_instr"}, instruction_o,      32'h0000_0013);
    chk({tag, "_pc"},    pc_data_o,          32'h0);
    chk({tag, "_ready"}, 32'(data_ready_o), 32'd0);
    chk({tag, "_clear"}, 32'(clear_o),      32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    chk("rv_reset_addr", rv_addr, 32'hFFFF_FFF8);

    // Streaming with single-cycle acks, then a 3-cycle stall on the ack of 0x8.
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    expect_word(32'h100);
    rst_i = 1'b0;
    tick();
    chk("idle_req", 32'(mem_req_o), 32'd1);
    chk("idle_addr", mem_addr_o, 32'h0);
    chk("idle_ready", 32'(data_ready_o), 32'd0);
    tick();
    chk("first_ready", 32'(data_ready_o), 32'd1);
    tick();
    stall_i = 1'b1;
    tick();
    chk("stall_req_drop", 32'(mem_req_o), 32'd0);
    chk("stall_ready", 32'(data_ready_o), 32'd0);
    chk("stall_pc", pc_data_o, 32'h4);
    tick();
    tick();
    chk("hold_pc", pc_data_o, 32'h4);
    chk("hold_instr", instruction_o, 32'h4);
    chk("hold_ready", 32'(data_ready_o), 32'd0);
    stall_i = 1'b0;
    tick();
    chk("release_ready", 32'(data_ready_o), 32'd1);
    chk("release_pc", pc_data_o, 32'h8);

    // 3-cycle latency; redirect to 0x103 one cycle after the 0x10 request.
    lat = 3;
    wait_ready("wait_word_c", 8);
    chk("req10_addr", mem_addr_o, 32'h10);
    jump_i        = 1'b1;
    jump_target_i = 32'h103;
    tick();
    chk("jump_clear", 32'(clear_o), 32'd1);
    chk("jump_ready", 32'(data_ready_o), 32'd0);
    chk("discard_addr", mem_addr_o, 32'h10);
    jump_i = 1'b0;
    tick();
    chk("clear_one_cycle", 32'(clear_o), 32'd0);
    wait_ready("wait_target", 10);
    chk("target_pc", pc_data_o, 32'h100);

    // Jump coincident with ack and stall.
    lat           = 1;
    data_xor      = 32'h5A5A_0000;
    stall_i       = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = 32'h200;
    tick();
    chk("jack_clear", 32'(clear_o), 32'd1);
    chk("jack_ready", 32'(data_ready_o), 32'd0);
    chk("jack_addr", mem_addr_o, 32'h200);
    jump_i  = 1'b0;
    stall_i = 1'b0;
    expect_word(32'h200);
    tick();
    chk("jack_resume", 32'(data_ready_o), 32'd1);

    // Jump while holding a buffered word.
    stall_i = 1'b1;
    tick();
    chk("hold2_req", 32'(mem_req_o), 32'd0);
    chk("hold2_pc", pc_data_o, 32'h200);
    jump_i        = 1'b1;
    jump_target_i = 32'h300;
    tick();
    chk("holdjump_clear", 32'(clear_o), 32'd1);
    chk("holdjump_addr", mem_addr_o, 32'h300);
    jump_i  = 1'b0;
    stall_i = 1'b0;
    expect_word(32'h300);
    tick();
    chk("holdjump_resume", 32'(data_ready_o), 32'd1);

    // Retarget while discarding.
    lat           = 4;
    jump_i        = 1'b1;
    jump_target_i = 32'h400;
    tick();
    chk("disc_clear", 32'(clear_o), 32'd1);
    chk("disc_addr", mem_addr_o, 32'h304);
    jump_target_i = 32'h500;
    tick();
    chk("retarget_clear", 32'(clear_o), 32'd1);
    chk("retarget_addr", mem_addr_o, 32'h304);
    jump_i = 1'b0;
    expect_word(32'h500);
    wait_ready("wait_retarget", 12);
    chk("retarget_pc", pc_data_o, 32'h500);

    // Wrap at the top of the address space.
    lat           = 1;
    jump_i        = 1'b1;
    jump_target_i = 32'hFFFF_FFFE;
    tick();
    chk("wrap_clear", 32'(clear_o), 32'd1);
    chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
    jump_i = 1'b0;
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0);
    tick();
    tick();
    chk("wrap_pc", pc_data_o, 32'h0);

    // Reset with the 0x4 request outstanding and an ack forced during/after reset.
    rst_i     = 1'b1;
    force_ack = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    expect_word(32'h0);
    rst_i = 1'b0;
    tick();
    force_ack = 1'b0;
    chk("post_idle_ready", 32'(data_ready_o), 32'd0);
    chk("post_req", 32'(mem_req_o), 32'd1);
    chk("post_addr", mem_addr_o, 32'h0);
    tick();
    chk("post_ready", 32'(data_ready_o), 32'd1);
    stall_i = 1'b1;
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    chk("rv_count", 32'(rv_seen.size()), 32'd3);
    if (rv_seen.size() == 3) begin
      chk("rv_pc0", rv_seen[0], 32'hFFFF_FFF8);
      chk("rv_pc1", rv_seen[1], 32'hFFFF_FFFC);
      chk("rv_pc2", rv_seen[2], 32'h0000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
